// File: rtl/posit_stream_pkg.sv
// Shared types and constants for the posit result stream.
// The entry layout below is the canonical 32-bit posit / 16-bit tag format;
// the collector builds an identically ordered entry from its own parameters.
package posit_stream_pkg;

   localparam int POSIT_N     = 32;
   localparam int POSIT_TAG_W = 16;

   // Not-a-Real encoding for a 32-bit posit: sign bit set, all other bits clear.
   localparam logic [31:0] NAR_32 = 32'h8000_0000;

   typedef struct packed {
      logic [POSIT_N-1:0]     data;
      logic [POSIT_TAG_W-1:0] tag;
      logic                   inf;
      logic                   zero;
      logic                   last;
   } posit_entry_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DRAIN   = 2'd2,
      DONE    = 2'd3
   } collector_state_e;

endpackage

// File: rtl/posit_result_collector_fifo.sv
// stream_fifo: flop-based FIFO whose head entry is driven straight from the
// storage registers, so a push is visible on the output the following cycle.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// Storage is not reset; only the pointers are.
module stream_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_data,
   output logic         push_ok,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic         full,
   output logic         drained_next
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic [AW:0]  level;
   logic [W-1:0] mem [DEPTH];
   logic         empty;
   logic         pop;
   logic         wr_en;

   assign level     = wr_ptr - rd_ptr;
   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign out_valid = !empty;
   assign pop       = out_valid && out_ready;
   // A pop in the same cycle frees the slot the write is about to use.
   assign push_ok   = !full || pop;
   assign wr_en     = push && push_ok;

   // Present zeros while empty so the stream outputs are quiet out of reset.
   assign out_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

   // True when nothing will remain after this cycle's pop (no push expected).
   assign drained_next = empty || ((level == (AW+1)'(1)) && pop);

   // Pointer update: control state, cleared by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)   rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // Storage write: data path, never reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/posit_result_collector.sv
// posit_result_collector: captures accumulator results on acc_done, tags them
// with their index in the current batch, buffers them in a FIFO and drains
// them as a valid/ready stream. Pulses batch_done once a batch has fully
// drained. Captures that find the FIFO full are dropped and counted, but
// still advance the batch so it always terminates.
module posit_result_collector
   import posit_stream_pkg::*;
#(
   parameter int N     = POSIT_N,
   parameter int DEPTH = 8,
   parameter int TAG_W = POSIT_TAG_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             batch_start,
   input  logic [TAG_W-1:0] batch_len,
   input  logic [N-1:0]     acc_result,
   input  logic             acc_inf,
   input  logic             acc_zero,
   input  logic             acc_done,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N-1:0]     out_data,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_inf,
   output logic             out_zero,
   output logic             out_last,
   output logic             batch_done,
   output logic             busy,
   output logic             overflow,
   output logic [7:0]       drop_count
);

   // Same field order as posit_entry_t, sized from this instance's parameters.
   typedef struct packed {
      logic [N-1:0]     data;
      logic [TAG_W-1:0] tag;
      logic             inf;
      logic             zero;
      logic             last;
   } entry_t;

   localparam int EW = $bits(entry_t);

   collector_state_e state;
   collector_state_e state_nxt;

   logic [TAG_W-1:0] len_q;
   logic [TAG_W-1:0] cap_cnt;
   logic             cap_last;
   logic             push;
   logic             push_ok;
   logic             fifo_full;
   logic             drained_next;
   entry_t           cap_entry;
   entry_t           head_entry;
   logic [EW-1:0]    head_bits;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign cap_last = (cap_cnt == len_q - TAG_W'(1));
   assign push     = (state == COLLECT) && acc_done;

   // Assemble the entry captured this cycle.
   always_comb begin
      cap_entry      = '0;
      cap_entry.data = acc_result;
      cap_entry.tag  = cap_cnt;
      cap_entry.inf  = acc_inf;
      cap_entry.zero = acc_zero;
      cap_entry.last = cap_last;
   end

   stream_fifo #(
      .W     (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk          (clk),
      .rst          (rst),
      .push         (push),
      .push_data    (cap_entry),
      .push_ok      (push_ok),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (head_bits),
      .full         (fifo_full),
      .drained_next (drained_next)
   );

   assign head_entry = entry_t'(head_bits);
   assign out_data   = head_entry.data;
   assign out_tag    = head_entry.tag;
   assign out_inf    = head_entry.inf;
   assign out_zero   = head_entry.zero;
   assign out_last   = head_entry.last;

   assign batch_done = (state == DONE);
   assign busy       = (state != IDLE);

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // FSM next-state: arm on batch_start, collect until the last index is
   // captured (kept or dropped), drain, then a single DONE cycle.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (batch_start) state_nxt = (batch_len == '0) ? DONE : COLLECT;
         end
         COLLECT: begin
            if (acc_done && cap_last) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (drained_next) state_nxt = DONE;
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Batch length, capture index and drop bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         len_q      <= '0;
         cap_cnt    <= '0;
         overflow   <= 1'b0;
         drop_count <= '0;
      end else begin
         if ((state == IDLE) && batch_start) begin
            len_q   <= batch_len;
            cap_cnt <= '0;
         end
         if (push) begin
            cap_cnt <= cap_cnt + TAG_W'(1);
            if (!push_ok) begin
               overflow   <= 1'b1;
               drop_count <= sat_inc8(drop_count);
            end
         end
      end
   end

   // fifo_full is folded into push_ok; kept as a named net for debug visibility.
   logic unused_full;
   assign unused_full = fifo_full;

endmodule

// File: tb/tb_posit_result_collector.sv
// Bench for posit_result_collector: directed scenarios plus randomized batches,
// every cycle compared against a queue-based reference model.
module tb_posit_result_collector;
   import posit_stream_pkg::*;

   localparam int N     = 32;
   localparam int DEPTH = 8;
   localparam int TAG_W = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             batch_start;
   logic [TAG_W-1:0] batch_len;
   logic [N-1:0]     acc_result;
   logic             acc_inf;
   logic             acc_zero;
   logic             acc_done;
   logic             out_valid;
   logic             out_ready;
   logic [N-1:0]     out_data;
   logic [TAG_W-1:0] out_tag;
   logic             out_inf;
   logic             out_zero;
   logic             out_last;
   logic             batch_done;
   logic             busy;
   logic             overflow;
   logic [7:0]       drop_count;

   always #5 clk = ~clk;

   posit_result_collector #(.N(N), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .batch_start (batch_start),
      .batch_len   (batch_len),
      .acc_result  (acc_result),
      .acc_inf     (acc_inf),
      .acc_zero    (acc_zero),
      .acc_done    (acc_done),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_tag     (out_tag),
      .out_inf     (out_inf),
      .out_zero    (out_zero),
      .out_last    (out_last),
      .batch_done  (batch_done),
      .busy        (busy),
      .overflow    (overflow),
      .drop_count  (drop_count)
   );

   // Reference model: queue of pending entries plus batch bookkeeping.
   posit_entry_t mq[$];
   int phase   = 0;   // 0 idle, 1 collecting, 2 draining, 3 done pulse
   int m_cnt   = 0;
   int m_len   = 0;
   bit m_ovf   = 1'b0;
   int m_drops = 0;

   int total = 0;
   int bad   = 0;

   // Observed-event counters for directed scenarios.
   int n_hs, n_last, n_done, n_vld;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clr_counts();
      n_hs = 0; n_last = 0; n_done = 0; n_vld = 0;
   endtask

   task automatic quiet_inputs();
      batch_start = 1'b0;
      acc_done    = 1'b0;
      acc_inf     = 1'b0;
      acc_zero    = 1'b0;
      acc_result  = '0;
   endtask

   task automatic check_outputs();
      chk("out_valid", {63'd0, out_valid}, {63'd0, mq.size() != 0});
      if (mq.size() != 0) begin
         chk("out_data", {32'd0, out_data}, {32'd0, mq[0].data});
         chk("out_tag",  {48'd0, out_tag},  {48'd0, mq[0].tag});
         chk("out_inf",  {63'd0, out_inf},  {63'd0, mq[0].inf});
         chk("out_zero", {63'd0, out_zero}, {63'd0, mq[0].zero});
         chk("out_last", {63'd0, out_last}, {63'd0, mq[0].last});
      end
      chk("batch_done", {63'd0, batch_done}, {63'd0, phase == 3});
      chk("busy",       {63'd0, busy},       {63'd0, phase != 0});
      chk("overflow",   {63'd0, overflow},   {63'd0, m_ovf});
      chk("drop_count", {56'd0, drop_count}, 64'(m_drops));
   endtask

   // One clock: compare, advance the model with the driven inputs, clock.
   task automatic cycle();
      bit           pop;
      bit           room;
      posit_entry_t e;
      check_outputs();
      if (out_valid && out_ready) n_hs++;
      if (out_valid && out_ready && out_last) n_last++;
      if (batch_done) n_done++;
      if (out_valid) n_vld++;
      pop  = (mq.size() != 0) && out_ready;
      room = (mq.size() < DEPTH) || pop;
      if (rst) begin
         mq.delete();
         phase = 0; m_cnt = 0; m_len = 0; m_ovf = 1'b0; m_drops = 0;
      end else begin
         if (pop) void'(mq.pop_front());
         case (phase)
            0: if (batch_start) begin
                  m_len = int'(batch_len);
                  m_cnt = 0;
                  phase = (batch_len == 0) ? 3 : 1;
               end
            1: if (acc_done) begin
                  e.data = acc_result;
                  e.tag  = m_cnt[TAG_W-1:0];
                  e.inf  = acc_inf;
                  e.zero = acc_zero;
                  e.last = (m_cnt == m_len - 1);
                  if (room) mq.push_back(e);
                  else begin
                     m_ovf = 1'b1;
                     if (m_drops < 255) m_drops++;
                  end
                  if (e.last) phase = 2;
                  m_cnt++;
               end
            2: if (mq.size() == 0) phase = 3;
            default: phase = 0;
         endcase
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      quiet_inputs();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
   endtask

   task automatic start_batch(input int len);
      batch_start = 1'b1;
      batch_len   = TAG_W'(len);
      cycle();
      batch_start = 1'b0;
   endtask

   task automatic rand_capture();
      acc_done   = 1'b1;
      acc_result = $urandom();
      acc_inf    = ($urandom_range(0, 7) == 0);
      acc_zero   = 1'b0;
      if (acc_inf) acc_result = NAR_32;
      else if ($urandom_range(0, 7) == 0) begin
         acc_zero   = 1'b1;
         acc_result = '0;
      end
   endtask

   logic [31:0] t1_data [4];
   logic        t1_inf  [4];
   logic        t1_zero [4];

   initial begin
      t1_data = '{32'h4000_0000, 32'h3800_0000, 32'h0000_0000, NAR_32};
      t1_inf  = '{1'b0, 1'b0, 1'b0, 1'b1};
      t1_zero = '{1'b0, 1'b0, 1'b1, 1'b0};
      clr_counts();
      quiet_inputs();
      batch_len = '0;
      out_ready = 1'b0;
      rst       = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;

      // Reset state.
      chk("rst_out_valid",  {63'd0, out_valid},  64'd0);
      chk("rst_out_data",   {32'd0, out_data},   64'd0);
      chk("rst_out_tag",    {48'd0, out_tag},    64'd0);
      chk("rst_out_last",   {63'd0, out_last},   64'd0);
      chk("rst_batch_done", {63'd0, batch_done}, 64'd0);
      chk("rst_busy",       {63'd0, busy},       64'd0);
      chk("rst_overflow",   {63'd0, overflow},   64'd0);
      chk("rst_drop_count", {56'd0, drop_count}, 64'd0);
      rst = 1'b0;

      // Scenario 1: four results with mixed flags, consumer always ready.
      clr_counts();
      out_ready = 1'b1;
      start_batch(4);
      for (int i = 0; i < 4; i++) begin
         acc_done   = 1'b1;
         acc_result = t1_data[i];
         acc_inf    = t1_inf[i];
         acc_zero   = t1_zero[i];
         cycle();
      end
      quiet_inputs();
      repeat (6) cycle();
      chk("t1_entries", 64'(n_hs),   64'd4);
      chk("t1_last",    64'(n_last), 64'd1);
      chk("t1_done",    64'(n_done), 64'd1);

      // Scenario 2: overfill by two with the consumer stalled.
      do_reset();
      clr_counts();
      out_ready = 1'b0;
      start_batch(10);
      for (int i = 0; i < 10; i++) begin
         rand_capture();
         cycle();
      end
      quiet_inputs();
      cycle();
      chk("t2_overflow", {63'd0, overflow},   64'd1);
      chk("t2_drops",    {56'd0, drop_count}, 64'd2);
      out_ready = 1'b1;
      repeat (14) cycle();
      chk("t2_entries", 64'(n_hs),   64'd8);
      chk("t2_last",    64'(n_last), 64'd0);
      chk("t2_done",    64'(n_done), 64'd1);

      // Scenario 3: capture into a full FIFO while it pops.
      do_reset();
      clr_counts();
      out_ready = 1'b0;
      start_batch(9);
      for (int i = 0; i < 8; i++) begin
         rand_capture();
         cycle();
      end
      rand_capture();
      out_ready = 1'b1;
      cycle();
      quiet_inputs();
      chk("t3_overflow", {63'd0, overflow},   64'd0);
      chk("t3_drops",    {56'd0, drop_count}, 64'd0);
      repeat (12) cycle();
      chk("t3_entries", 64'(n_hs),   64'd9);
      chk("t3_last",    64'(n_last), 64'd1);
      chk("t3_done",    64'(n_done), 64'd1);

      // Scenario 4: zero-length batch.
      do_reset();
      clr_counts();
      start_batch(0);
      chk("t4_done_now", {63'd0, batch_done}, 64'd1);
      repeat (4) cycle();
      chk("t4_valid_seen", 64'(n_vld),  64'd0);
      chk("t4_done_count", 64'(n_done), 64'd1);

      // Scenario 5: acc_done while idle, batch_start while collecting.
      clr_counts();
      for (int i = 0; i < 3; i++) begin
         rand_capture();
         cycle();
      end
      quiet_inputs();
      cycle();
      chk("t5_idle_valid", 64'(n_vld), 64'd0);
      chk("t5_idle_busy",  {63'd0, busy}, 64'd0);
      start_batch(3);
      rand_capture();
      batch_start = 1'b1;
      batch_len   = TAG_W'(7);
      cycle();
      batch_start = 1'b0;
      chk("t5_busy", {63'd0, busy}, 64'd1);
      for (int i = 0; i < 2; i++) begin
         rand_capture();
         cycle();
      end
      quiet_inputs();
      repeat (6) cycle();
      chk("t5_entries", 64'(n_hs),   64'd3);
      chk("t5_last",    64'(n_last), 64'd1);
      chk("t5_done",    64'(n_done), 64'd1);

      // Scenario 6: reset during drain with three entries queued.
      clr_counts();
      out_ready = 1'b0;
      start_batch(3);
      for (int i = 0; i < 3; i++) begin
         rand_capture();
         cycle();
      end
      quiet_inputs();
      cycle();
      chk("t6_busy_before", {63'd0, busy}, 64'd1);
      do_reset();
      chk("t6_out_valid", {63'd0, out_valid}, 64'd0);
      chk("t6_busy",      {63'd0, busy},      64'd0);
      chk("t6_overflow",  {63'd0, overflow},  64'd0);
      out_ready = 1'b1;
      repeat (5) cycle();
      chk("t6_done", 64'(n_done), 64'd0);

      // Randomized batches with random back-pressure and stray control pulses.
      for (int b = 0; b < 20; b++) begin
         start_batch($urandom_range(1, 12));
         for (int c = 0; c < 300; c++) begin
            if (phase == 0) break;
            quiet_inputs();
            if ($urandom_range(0, 9) < 6) rand_capture();
            if ($urandom_range(0, 7) == 0) begin
               batch_start = 1'b1;
               batch_len   = TAG_W'($urandom_range(0, 15));
            end
            out_ready = ($urandom_range(0, 1) == 1);
            cycle();
         end
         chk("rand_batch_end", 64'(phase), 64'd0);
         quiet_inputs();
         if ($urandom_range(0, 3) == 0) do_reset();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1);
   end

endmodule
